reg_file_16: RTL and testbench

//  16 x 16-bit general-purpose register file; directly downstream of the write-back 2:1 mux.
//  The mux output (ALU result vs. memory data) arrives on WD and is written on the clock edge.
//  Two combinational read ports feed the operand-select muxes.
//  A same-cycle write->read bypass lets a value being written be read back in the same cycle.

---
 rtl/proc16_pkg.sv | 12 +
 rtl/rf_read_port.sv | 48 ++++
 rtl/reg_file_16.sv | 63 ++++++
 tb/tb_reg_file_16.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/proc16_pkg.sv
// Shared widths, constants and types for the 16-bit processor datapath.
package proc16_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 4'd0;
endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: storage select, same-cycle write bypass, r0 forcing.
// Zero latency; no flow control, output follows inputs combinationally.
module rf_read_port
  import proc16_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b1
) (
  input  word_t     i_regs [DEPTH],
  input  logic      i_we,
  input  logic      i_clr,
  input  reg_addr_t i_wa,
  input  word_t     i_wd,
  input  reg_addr_t i_ra,
  output word_t     o_rd
);

  logic  w_wa_zero;
  logic  w_ra_zero;
  logic  w_byp;
  word_t w_rd;

  assign w_wa_zero = ZERO_R0 && (i_wa == REG_ZERO);
  assign w_ra_zero = ZERO_R0 && (i_ra == REG_ZERO);
  assign w_byp     = i_we && !i_clr && !w_wa_zero && (i_ra == i_wa);

  // Unknown read address, or unknown write address during a write, poisons the port.
  always_comb begin
    w_rd = '0;
    case ({i_we && $isunknown(i_wa), $isunknown(i_ra)})
      2'b00: begin
        if (w_ra_zero) begin
          w_rd = '0;
        end else if (w_byp) begin
          w_rd = i_wd;
        end else begin
          w_rd = i_regs[i_ra];
        end
      end
      default: begin
        w_rd = 'x;
        assert (1'b0) else $error("rf_read_port: unknown register address");
      end
    endcase
  end

  assign o_rd = w_rd;

endmodule

// File: rtl/reg_file_16.sv
// 16 x 16-bit register file: 1-cycle write, two zero-latency read ports with write bypass.
// Always ready; no backpressure. Synchronous clear outranks write; async reset outranks both.
module reg_file_16
  import proc16_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_we,
  input  reg_addr_t        i_wa,
  input  word_t            i_wd,
  input  reg_addr_t        i_ra1,
  input  reg_addr_t        i_ra2,
  output word_t            o_rd1,
  output word_t            o_rd2,
  output logic [CNT_W-1:0] o_wr_cnt
);

  word_t            r_regs [DEPTH];
  logic [CNT_W-1:0] r_wr_cnt;
  logic             w_commit;

  // A write to the hard-wired zero register is dropped and not counted.
  assign w_commit = i_we && !i_clr && !(ZERO_R0 && (i_wa == REG_ZERO));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_wr_cnt <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_wr_cnt <= '0;
    end else if (w_commit) begin
      r_regs[i_wa] <= i_wd;
      if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  rf_read_port #(.ZERO_R0(ZERO_R0)) u_rd1 (
    .i_regs (r_regs),
    .i_we   (i_we),
    .i_clr  (i_clr),
    .i_wa   (i_wa),
    .i_wd   (i_wd),
    .i_ra   (i_ra1),
    .o_rd   (o_rd1)
  );

  rf_read_port #(.ZERO_R0(ZERO_R0)) u_rd2 (
    .i_regs (r_regs),
    .i_we   (i_we),
    .i_clr  (i_clr),
    .i_wa   (i_wa),
    .i_wd   (i_wd),
    .i_ra   (i_ra2),
    .o_rd   (o_rd2)
  );

  assign o_wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_reg_file_16.sv
// Bench for reg_file_16: directed vector table, randomized traffic, sweep/saturation, mid-cycle reset.
module tb_reg_file_16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wa = '0;
  logic [15:0] wd = '0;
  logic [3:0]  ra1 = '0;
  logic [3:0]  ra2 = '0;
  logic [15:0] rd1, rd2, nz_rd1, nz_rd2;
  logic [7:0]  cnt, nz_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: m1/c1 for the zero-r0 build, m0/c0 for the plain build.
  logic [15:0] m1 [16];
  logic [15:0] m0 [16];
  int          c1, c0;

  always #5 clk = ~clk;

  reg_file_16 #(.ZERO_R0(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_we(we), .i_wa(wa), .i_wd(wd),
    .i_ra1(ra1), .i_ra2(ra2), .o_rd1(rd1), .o_rd2(rd2), .o_wr_cnt(cnt)
  );

  reg_file_16 #(.ZERO_R0(1'b0)) dut_nz (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_we(we), .i_wa(wa), .i_wd(wd),
    .i_ra1(ra1), .i_ra2(ra2), .o_rd1(nz_rd1), .o_rd2(nz_rd2), .o_wr_cnt(nz_cnt)
  );

  typedef struct {
    logic        we;
    logic        clr;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m1[i] = '0;
      m0[i] = '0;
    end
    c1 = 0;
    c0 = 0;
  endtask

  task automatic model_edge();
    if (clr) begin
      model_reset();
    end else if (we) begin
      m0[wa] = wd;
      if (c0 < 255) c0++;
      if (wa != 4'd0) begin
        m1[wa] = wd;
        if (c1 < 255) c1++;
      end
    end
  endtask

  function automatic logic [15:0] exp_rd(input bit z, input logic [3:0] ra);
    bit wr_ok;
    wr_ok = we && !clr && !(z && wa == 4'd0);
    if (z && ra == 4'd0) return 16'h0000;
    if (wr_ok && ra == wa) return wd;
    return z ? m1[ra] : m0[ra];
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_rd1"}, rd1, exp_rd(1'b1, ra1));
    check({tag, "_rd2"}, rd2, exp_rd(1'b1, ra2));
    check({tag, "_cnt"}, {8'h00, cnt}, 16'(c1));
    check({tag, "_nz_rd1"}, nz_rd1, exp_rd(1'b0, ra1));
    check({tag, "_nz_rd2"}, nz_rd2, exp_rd(1'b0, ra2));
    check({tag, "_nz_cnt"}, {8'h00, nz_cnt}, 16'(c0));
  endtask

  task automatic drive(input logic w, input logic c, input logic [3:0] a, input logic [15:0] d,
                       input logic [3:0] r1, input logic [3:0] r2);
    we = w; clr = c; wa = a; wd = d; ra1 = r1; ra2 = r2;
  endtask

  // Compare pre-edge (combinational) outputs, then clock once and advance the model.
  task automatic step(input string tag);
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd3, 16'hBEEF, 4'd3, 4'd0, 16'hBEEF, 16'h0000, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd3, 16'hBEEF, 16'hBEEF, 8'd1};
    vecs[2] = '{1'b1, 1'b0, 4'd5, 16'h1234, 4'd5, 4'd5, 16'h1234, 16'h1234, 8'd1};
    vecs[3] = '{1'b1, 1'b0, 4'd0, 16'hFFFF, 4'd0, 4'd5, 16'h0000, 16'h1234, 8'd2};
    vecs[4] = '{1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd3, 16'h0000, 16'hBEEF, 8'd2};
    vecs[5] = '{1'b1, 1'b1, 4'd7, 16'hAAAA, 4'd7, 4'd3, 16'h0000, 16'hBEEF, 8'd2};
    vecs[6] = '{1'b0, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd5, 16'h0000, 16'h0000, 8'd0};
    vecs[7] = '{1'b1, 1'b0, 4'd7, 16'h5555, 4'd7, 4'd6, 16'h5555, 16'h0000, 8'd0};
    vecs[8] = '{1'b0, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 16'h5555, 16'h5555, 8'd1};

    model_reset();
    ra1 = 4'd3;
    ra2 = 4'd9;
    #2;
    check("reset_rd1", rd1, 16'h0000);
    check("reset_rd2", rd2, 16'h0000);
    check("reset_cnt", {8'h00, cnt}, 16'h0000);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table; zero-r0 build against fixed values, plain build against the model.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].clr, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      @(negedge clk);
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
      check($sformatf("vec%0d_cnt", i), {8'h00, cnt}, {8'h00, vecs[i].ec});
      check($sformatf("vec%0d_nz_rd1", i), nz_rd1, exp_rd(1'b0, ra1));
      check($sformatf("vec%0d_nz_cnt", i), {8'h00, nz_cnt}, 16'(c0));
      if (i == 4) check("vec4_nz_r0_holds_ffff", nz_rd1, 16'hFFFF);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Randomized traffic with address collisions biased in.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(15));
      drive(1'($urandom_range(1)), ($urandom_range(15) == 0), a, 16'($urandom),
            ($urandom_range(2) == 0) ? a : 4'($urandom_range(15)),
            ($urandom_range(2) == 0) ? a : 4'($urandom_range(15)));
      step($sformatf("rand%0d", n));
    end

    // Sweep every register repeatedly until the write counter saturates.
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 1'b0, 4'(n % 16), 16'(n % 16) * 16'h1111, 4'(n % 16), 4'((n + 1) % 16));
      step($sformatf("sweep%0d", n));
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
    for (int a = 0; a < 16; a++) begin
      logic [15:0] v1, v2;
      ra1 = 4'(a);
      ra2 = 4'(15 - a);
      v1 = 16'(a) * 16'h1111;
      v2 = 16'(15 - a) * 16'h1111;
      #1;
      check($sformatf("swp_rd1_r%0d", a), rd1, v1);
      check($sformatf("swp_rd2_r%0d", 15 - a), rd2, v2);
      check($sformatf("swp_nz_rd1_r%0d", a), nz_rd1, v1);
    end
    check("sat_cnt", {8'h00, cnt}, 16'h00FF);
    check("sat_nz_cnt", {8'h00, nz_cnt}, 16'h00FF);

    // Mid-cycle reset: immediate clear, and a write pending under reset is lost.
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd1", rd1, 16'h0000);
    check("arst_rd2", rd2, 16'h0000);
    check("arst_cnt", {8'h00, cnt}, 16'h0000);
    check("arst_nz_cnt", {8'h00, nz_cnt}, 16'h0000);
    model_reset();
    drive(1'b1, 1'b0, 4'd9, 16'h7777, 4'd3, 4'd10);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd9, 4'd9);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_lost_rd1", rd1, 16'h0000);
    check("arst_lost_cnt", {8'h00, cnt}, 16'h0000);
    drive(1'b1, 1'b0, 4'd2, 16'h0F0F, 4'd2, 4'd9);
    step("post_rst_wr");
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd2);
    #1;
    check("post_rst_rd1", rd1, 16'h0F0F);
    check("post_rst_cnt", {8'h00, cnt}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
